mmio_io_ctrl: RTL and testbench

- Memory-mapped I/O controller: the CPU data path reaches board LEDs, switches and the multi-digit seven-segment display through word-addressed registers instead of hard-wired register taps.
- Sits beside dmemory32 on the ALU-result/read_data_2 buses; the top decodes the I/O address window and drives io_wen/io_ren.
- Generalises the fixed 8-digit display and the fixed 24-bit switch/LED widths into parameters.
- Adds switch synchronisation, debounce, sticky change flags and digit blanking.

---
 rtl/mmio_io_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mmio_io_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_ctrl.sv
// Word-addressed I/O register block for LEDs, debounced switches and a scanned
// multi-digit seven-segment display.
module mmio_io_ctrl #(
  parameter int LED_W           = 24,
  parameter int SW_W            = 24,
  parameter int DIGITS          = 8,
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        io_addr,
  input  logic              io_wen,
  input  logic              io_ren,
  input  logic [31:0]       io_wdata,
  output logic [31:0]       io_rdata,
  input  logic [SW_W-1:0]   switch_i,
  output logic [LED_W-1:0]  led_o,
  output logic [7:0]        segment_led,
  output logic [7:0]        seg_en
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Bus: no handshake; io_wen is a one-cycle strobe committing io_wdata at that
  // edge, io_rdata is a pure function of io_addr/io_ren and current state.
  logic [2:0]        word;
  logic              unused_addr_bits;
  logic [LED_W-1:0]  led;
  logic [31:0]       seg_data;
  logic              seg_on;
  logic [DIGITS-1:0] seg_blank;
  logic [SW_W-1:0]   sync_a;
  logic [SW_W-1:0]   sync;
  logic [SW_W-1:0]   stable;
  logic [SW_W-1:0]   sw_chg;
  logic [DW-1:0]     deb_cnt;
  logic              sw_update;
  logic [SW_W-1:0]   chg_set;
  logic [SW_W-1:0]   chg_clr;
  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  logic [4:0]        bit_base;
  logic [3:0]        nibble;
  logic              digit_lit;

  assign word             = io_addr[4:2];
  assign unused_addr_bits = ^io_addr[1:0];
  assign led_o            = led;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led       <= '0;
      seg_data  <= '0;
      seg_on    <= 1'b1;
      seg_blank <= '0;
    end else if (io_wen) begin
      case (word)
        3'd0: led <= io_wdata[LED_W-1:0];
        3'd1: seg_data <= io_wdata;
        3'd2: begin
          seg_on    <= io_wdata[0];
          seg_blank <= io_wdata[8 +: DIGITS];
        end
        default: ;
      endcase
    end
  end

  // The counter only clears when sync settles back onto stable, so a bouncing
  // input that keeps differing still gets accepted after DEBOUNCE_CYCLES.
  assign sw_update = (sync != stable) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign chg_set   = sw_update ? (stable ^ sync) : '0;
  assign chg_clr   = (io_wen && word == 3'd4) ? io_wdata[SW_W-1:0] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a  <= '0;
      sync    <= '0;
      stable  <= '0;
      deb_cnt <= '0;
      sw_chg  <= '0;
    end else begin
      sync_a <= switch_i;
      sync   <= sync_a;
      if (sync == stable) begin
        deb_cnt <= '0;
      end else if (sw_update) begin
        stable  <= sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      sw_chg <= (sw_chg & ~chg_clr) | chg_set;
    end
  end

  assign bit_base  = 5'(idx) << 2;
  assign nibble    = seg_data[bit_base +: 4];
  assign digit_lit = seg_on && !seg_blank[idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      idx         <= '0;
      seg_en      <= 8'hFF;
      segment_led <= 8'hFF;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (digit_lit) begin
        seg_en      <= ~(8'h01 << idx);
        segment_led <= ~{1'b0, hex7(nibble)};
      end else begin
        seg_en      <= 8'hFF;
        segment_led <= 8'hFF;
      end
    end
  end

  always_comb begin
    io_rdata = '0;
    if (io_ren) begin
      case (word)
        3'd0: io_rdata = 32'(led);
        3'd1: io_rdata = seg_data;
        3'd2: begin
          io_rdata[0]           = seg_on;
          io_rdata[8 +: DIGITS] = seg_blank;
        end
        3'd3: io_rdata = 32'(stable);
        3'd4: io_rdata = 32'(sw_chg);
        default: io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Randomised and directed bench for mmio_io_ctrl against a time-based reference
// model of the register map, switch debounce and display scan.
module tb_mmio_io_ctrl;

  localparam int LED_W  = 24;
  localparam int SW_W   = 24;
  localparam int DIGITS = 8;
  localparam int SCAN_DIV = 4;
  localparam int DEB    = 3;
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF01;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       io_addr;
  logic             io_wen;
  logic             io_ren;
  logic [31:0]      io_wdata;
  logic [31:0]      io_rdata;
  logic [SW_W-1:0]  switch_i;
  logic [LED_W-1:0] led_o;
  logic [7:0]       segment_led;
  logic [7:0]       seg_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [23:0] m_led, m_stable, m_chg;
  logic [31:0] m_data, m_ctrl;
  int          m_cycles;
  int          m_run;
  logic [23:0] sync_q[$];
  logic [15:0] exp_q[$];

  mmio_io_ctrl #(
    .LED_W(LED_W), .SW_W(SW_W), .DIGITS(DIGITS),
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock(clock), .reset(reset), .io_addr(io_addr), .io_wen(io_wen),
    .io_ren(io_ren), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .switch_i(switch_i), .led_o(led_o), .segment_led(segment_led), .seg_en(seg_en)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic ren);
    if (!ren) return 32'h0;
    case (a[4:2])
      3'd0: return {8'h0, m_led};
      3'd1: return m_data;
      3'd2: return m_ctrl;
      3'd3: return {8'h0, m_stable};
      3'd4: return {8'h0, m_chg};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_led = '0; m_stable = '0; m_chg = '0; m_data = '0; m_ctrl = 32'h1;
    m_cycles = 0; m_run = 0;
    sync_q.delete();
    sync_q.push_back(24'h0);
    sync_q.push_back(24'h0);
    exp_q.delete();
  endtask

  // One clock edge: predict what the edge produces from the inputs now applied.
  task automatic tick();
    int          digit;
    logic [7:0]  e_en, e_seg;
    logic [23:0] sync_cur, changes, w1c;
    logic [15:0] e;
    digit = (m_cycles / SCAN_DIV) % DIGITS;
    if (m_ctrl[0] && !m_ctrl[8 + digit]) begin
      e_en  = ~(8'h01 << digit);
      e_seg = ~{1'b0, ref_hex7(m_data[digit*4 +: 4])};
    end else begin
      e_en  = 8'hFF;
      e_seg = 8'hFF;
    end
    exp_q.push_back({e_en, e_seg});
    m_cycles++;
    sync_cur = sync_q[0];
    changes  = '0;
    if (sync_cur == m_stable) m_run = 0;
    else if (m_run == DEB - 1) begin
      changes  = m_stable ^ sync_cur;
      m_stable = sync_cur;
      m_run    = 0;
    end else m_run++;
    void'(sync_q.pop_front());
    sync_q.push_back(switch_i);
    w1c   = (io_wen && io_addr[4:2] == 3'd4) ? io_wdata[23:0] : 24'h0;
    m_chg = (m_chg & ~w1c) | changes;
    if (io_wen) begin
      case (io_addr[4:2])
        3'd0: m_led = io_wdata[23:0];
        3'd1: m_data = io_wdata;
        3'd2: m_ctrl = io_wdata & CTRL_MASK;
        default: ;
      endcase
    end
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("seg_en", {24'h0, seg_en}, {24'h0, e[15:8]});
    check("segment_led", {24'h0, segment_led}, {24'h0, e[7:0]});
    check("led_o", {8'h0, led_o}, {8'h0, m_led});
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    io_addr = a; io_wdata = d; io_wen = 1'b1; io_ren = 1'b0;
    tick();
    io_wen = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, output logic [31:0] v);
    io_addr = a; io_ren = 1'b1; io_wen = 1'b0;
    #1;
    v = io_rdata;
    check(tag, v, model_read(a, 1'b1));
  endtask

  initial begin
    logic [31:0] v;
    logic        found;
    reset = 1'b1; io_addr = '0; io_wen = 1'b0; io_ren = 1'b0; io_wdata = '0; switch_i = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_led_o", {8'h0, led_o}, 32'h0);
    check("rst_seg_en", {24'h0, seg_en}, 32'hFF);
    check("rst_segment_led", {24'h0, segment_led}, 32'hFF);
    rd("rst_ctrl", 5'h08, v);
    check("rst_ctrl_c", v, 32'h1);
    rd("rst_data", 5'h04, v);
    reset = 1'b0;

    // LED register
    wr(5'h00, 32'h00AB_CDEF);
    rd("led_rd", 5'h00, v);
    check("led_rd_c", v, 32'h00AB_CDEF);
    check("led_o_c", {8'h0, led_o}, 32'h00AB_CDEF);
    wr(5'h00, 32'hFFFF_FFFF);
    rd("led_full", 5'h00, v);
    check("led_full_c", v, 32'h00FF_FFFF);

    // Display scan
    wr(5'h04, 32'h1234_5678);
    wr(5'h08, 32'h1);
    repeat (36) tick();
    wr(5'h08, 32'h301);
    rd("ctrl_rd", 5'h08, v);
    check("ctrl_rd_c", v, 32'h301);
    repeat (32) tick();
    wr(5'h08, 32'h0);
    repeat (16) tick();
    wr(5'h08, 32'h1);

    // Switch debounce latency and glitch rejection
    switch_i = 24'h000005;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd("sw_lat", 5'h0C, v);
      check("sw_lat_c", v, (k < 5) ? 32'h0 : 32'h5);
    end
    rd("chg_after", 5'h10, v);
    check("chg_after_c", v, 32'h5);
    switch_i = 24'h000001;
    tick();
    switch_i = 24'h000005;
    for (int k = 0; k < 8; k++) begin
      tick();
      rd("sw_glitch", 5'h0C, v);
      check("sw_glitch_c", v, 32'h5);
    end

    // SW_CHG clear, and set beating clear in the same cycle
    wr(5'h10, 32'h1);
    rd("chg_w1c", 5'h10, v);
    check("chg_w1c_c", v, 32'h4);
    switch_i = 24'h000001;
    repeat (4) tick();
    wr(5'h10, 32'h4);
    rd("chg_setwins", 5'h10, v);
    check("chg_setwins_c", v, 32'h4);
    rd("sw_new", 5'h0C, v);
    check("sw_new_c", v, 32'h1);
    wr(5'h10, 32'h4);
    rd("chg_clr", 5'h10, v);
    check("chg_clr_c", v, 32'h0);

    // Asynchronous reset mid-scan
    wr(5'h00, 32'h123);
    switch_i = 24'h000003;
    repeat (6) tick();
    rd("chg_pre_rst", 5'h10, v);
    repeat (3) tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_led_o", {8'h0, led_o}, 32'h0);
    check("arst_seg_en", {24'h0, seg_en}, 32'hFF);
    check("arst_segment_led", {24'h0, segment_led}, 32'hFF);
    rd("arst_chg", 5'h10, v);
    check("arst_chg_c", v, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    io_ren = 1'b0;
    found = 1'b0;
    for (int i = 0; i < SCAN_DIV + 1 && !found; i++) begin
      tick();
      if (seg_en == 8'hFE) found = 1'b1;
    end
    check("scan_restart", {31'h0, found}, 32'h1);
    rd("unmapped", 5'h1C, v);
    check("unmapped_c", v, 32'h0);
    io_addr = 5'h00; io_ren = 1'b0;
    #1;
    check("ren_low", io_rdata, 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      io_addr  = 5'($urandom_range(0, 31));
      io_wdata = $urandom;
      io_wen   = ($urandom_range(0, 3) == 0);
      io_ren   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) switch_i = 24'($urandom);
      #1;
      check("rand_rd", io_rdata, model_read(io_addr, io_ren));
      tick();
    end
    io_wen = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
